// File: rtl/alm_mul_arbiter.sv
// Round-robin arbiter sharing one external 16x16 signed multiplier among N_REQ requesters.
// Two-stage pipeline: an issue register drives the multiplier and a result register holds the tagged product.
module alm_mul_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_REQ-1:0]      i_req_valid,
  output logic [N_REQ-1:0]      o_req_ready,
  input  logic [16*N_REQ-1:0]   i_req_a,
  input  logic [16*N_REQ-1:0]   i_req_b,
  output logic [15:0]           o_mul_a,
  output logic [15:0]           o_mul_b,
  input  logic [31:0]           i_mul_z,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [ID_W-1:0]       o_rsp_id,
  output logic [31:0]           o_rsp_z,
  output logic [CNT_W-1:0]      o_issue_cnt
);

  logic              s1_valid;
  logic [ID_W-1:0]   s1_id;
  logic [15:0]       s1_a;
  logic [15:0]       s1_b;
  logic              s2_valid;
  logic [ID_W-1:0]   s2_id;
  logic [31:0]       s2_z;
  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  issue_cnt;

  logic              s2_load;
  logic              s1_free;
  logic              found;
  logic              accept;
  logic [ID_W-1:0]   gnt;
  logic [ID_W:0]     sum;
  logic [2*N_REQ-1:0] rot;
  logic [15:0]       sel_a;
  logic [15:0]       sel_b;

  assign s2_load = s1_valid & (~s2_valid | i_rsp_ready);
  assign s1_free = ~s1_valid | s2_load;

  // Rotating the doubled valid vector by rr_ptr turns the circular scan into a plain priority search.
  always_comb begin
    rot   = {i_req_valid, i_req_valid} >> rr_ptr;
    found = 1'b0;
    gnt   = '0;
    sum   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, rr_ptr} + (ID_W+1)'(k);
        if (sum >= (ID_W+1)'(N_REQ))
          sum = sum - (ID_W+1)'(N_REQ);
        gnt = sum[ID_W-1:0];
      end
    end
  end

  assign accept = s1_free & found & ~i_rst;

  always_comb begin
    o_req_ready = '0;
    sel_a       = '0;
    sel_b       = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt == ID_W'(i)) begin
        o_req_ready[i] = accept;
        sel_a          = i_req_a[16*i +: 16];
        sel_b          = i_req_b[16*i +: 16];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid  <= 1'b0;
      s1_id     <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s2_valid  <= 1'b0;
      s2_id     <= '0;
      s2_z      <= '0;
      rr_ptr    <= '0;
      issue_cnt <= '0;
    end else begin
      if (s2_load) begin
        s2_valid <= 1'b1;
        s2_id    <= s1_id;
        s2_z     <= i_mul_z;
      end else if (s2_valid && i_rsp_ready) begin
        s2_valid <= 1'b0;
      end

      if (accept) begin
        s1_valid <= 1'b1;
        s1_id    <= gnt;
        s1_a     <= sel_a;
        s1_b     <= sel_b;
        rr_ptr   <= (gnt == ID_W'(N_REQ-1)) ? '0 : gnt + ID_W'(1);
        if (issue_cnt != '1)
          issue_cnt <= issue_cnt + CNT_W'(1);
      end else if (s1_free) begin
        s1_valid <= 1'b0;
      end
    end
  end

  assign o_mul_a     = s1_valid ? s1_a : '0;
  assign o_mul_b     = s1_valid ? s1_b : '0;
  assign o_rsp_valid = s2_valid;
  assign o_rsp_id    = s2_id;
  assign o_rsp_z     = s2_z;
  assign o_issue_cnt = issue_cnt;

endmodule

// File: tb/tb_alm_mul_arbiter.sv
// Directed bench for alm_mul_arbiter with an exact multiplier model on the external port.
// A second instance with a 4-bit counter shares all inputs to exercise counter saturation.
module tb_alm_mul_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [31:0] mul_z;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_z;
  logic [15:0] issue_cnt;

  logic [3:0]  s_req_ready;
  logic [15:0] s_mul_a;
  logic [15:0] s_mul_b;
  logic [31:0] s_mul_z;
  logic        s_rsp_valid;
  logic [1:0]  s_rsp_id;
  logic [31:0] s_rsp_z;
  logic [3:0]  s_issue_cnt;

  int checks;
  int fails;

  assign mul_z   = 32'($signed(mul_a) * $signed(mul_b));
  assign s_mul_z = 32'($signed(s_mul_a) * $signed(s_mul_b));

  alm_mul_arbiter #(.N_REQ(4), .ID_W(2), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_a(req_a), .i_req_b(req_b), .o_mul_a(mul_a), .o_mul_b(mul_b),
    .i_mul_z(mul_z), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_id(rsp_id), .o_rsp_z(rsp_z), .o_issue_cnt(issue_cnt)
  );

  alm_mul_arbiter #(.N_REQ(4), .ID_W(2), .CNT_W(4)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(s_req_ready),
    .i_req_a(req_a), .i_req_b(req_b), .o_mul_a(s_mul_a), .o_mul_b(s_mul_b),
    .i_mul_z(s_mul_z), .o_rsp_valid(s_rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_id(s_rsp_id), .o_rsp_z(s_rsp_z), .o_issue_cnt(s_issue_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || issue_cnt !== 16'd0 || rsp_id !== 2'd0 || rsp_z !== 32'd0) begin
      $display("FAIL reset_outputs: got valid=%b cnt=%0d id=%0d z=%0h required 0/0/0/0",
               rsp_valid, issue_cnt, rsp_id, rsp_z);
      fails++;
    end
    checks++;
    if (mul_a !== 16'd0 || mul_b !== 16'd0 || req_ready !== 4'b0000) begin
      $display("FAIL reset_mul_ready: got a=%0h b=%0h ready=%b required 0/0/0000", mul_a, mul_b, req_ready);
      fails++;
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_op();
    rsp_ready = 1'b1;
    req_a[32 +: 16] = 16'd300;
    req_b[32 +: 16] = 16'(-7);
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      $display("FAIL single_ready: got %b required 0100", req_ready); fails++;
    end
    tick();
    req_valid = '0;
    #1;
    checks++;
    if (mul_a !== 16'd300 || mul_b !== 16'hFFF9 || rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      $display("FAIL single_issue: got a=%0h b=%0h rsp_valid=%b ready=%b required 12c/fff9/0/0000",
               mul_a, mul_b, rsp_valid, req_ready);
      fails++;
    end
    tick();
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_z !== 32'(-2100) || issue_cnt !== 16'd1) begin
      $display("FAIL single_rsp: got valid=%b id=%0d z=%0d cnt=%0d required 1/2/-2100/1",
               rsp_valid, rsp_id, $signed(rsp_z), issue_cnt);
      fails++;
    end
    tick();
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      $display("FAIL single_drain: got valid=%b required 0", rsp_valid); fails++;
    end
  endtask

  task automatic test_round_robin();
    logic signed [31:0] exp_z;
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_a[16*i +: 16] = 16'(100 * (i + 1));
      req_b[16*i +: 16] = 16'(-(i + 2));
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      if (k == 6) req_valid = '0;
      #1;
      if (k < 6) begin
        checks++;
        if (req_ready !== (4'b0001 << (k % 4))) begin
          $display("FAIL rr_grant[%0d]: got %b required %b", k, req_ready, 4'b0001 << (k % 4)); fails++;
        end
      end
      if (k >= 2 && k < 8) begin
        exp_z = -100 * ((k - 2) % 4 + 1) * ((k - 2) % 4 + 2);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'((k - 2) % 4) || rsp_z !== exp_z) begin
          $display("FAIL rr_rsp[%0d]: got valid=%b id=%0d z=%0d required 1/%0d/%0d",
                   k, rsp_valid, rsp_id, $signed(rsp_z), (k - 2) % 4, exp_z);
          fails++;
        end
      end
      if (k == 8) begin
        checks++;
        if (rsp_valid !== 1'b0 || issue_cnt !== 16'd6) begin
          $display("FAIL rr_end: got valid=%b cnt=%0d required 0/6", rsp_valid, issue_cnt); fails++;
        end
      end
      tick();
    end
  endtask

  // Entered with rr_ptr = 2 after the round-robin run.
  task automatic test_backpressure();
    rsp_ready = 1'b0;
    req_a[0 +: 16] = 16'd5;    req_b[0 +: 16] = 16'd6;
    req_a[16 +: 16] = 16'(-8); req_b[16 +: 16] = 16'd9;
    req_a[32 +: 16] = 16'd7;   req_b[32 +: 16] = 16'd7;
    req_valid = 4'b0011;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      $display("FAIL bp_grant0: got %b required 0001", req_ready); fails++;
    end
    tick();
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      $display("FAIL bp_grant1: got %b required 0010", req_ready); fails++;
    end
    tick();
    req_valid = 4'b0100;
    for (int k = 2; k < 5; k++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_z !== 32'd30 ||
          mul_a !== 16'hFFF8 || mul_b !== 16'd9) begin
        $display("FAIL bp_stall[%0d]: got ready=%b valid=%b id=%0d z=%0d a=%0h b=%0h required 0000/1/0/30/fff8/9",
                 k, req_ready, rsp_valid, rsp_id, $signed(rsp_z), mul_a, mul_b);
        fails++;
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100 || rsp_id !== 2'd0 || rsp_z !== 32'd30) begin
      $display("FAIL bp_release: got ready=%b id=%0d z=%0d required 0100/0/30", req_ready, rsp_id, $signed(rsp_z));
      fails++;
    end
    tick();
    req_valid = '0;
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_z !== 32'(-72)) begin
      $display("FAIL bp_drain1: got valid=%b id=%0d z=%0d required 1/1/-72", rsp_valid, rsp_id, $signed(rsp_z));
      fails++;
    end
    tick();
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_z !== 32'd49) begin
      $display("FAIL bp_drain2: got valid=%b id=%0d z=%0d required 1/2/49", rsp_valid, rsp_id, $signed(rsp_z));
      fails++;
    end
    tick();
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || issue_cnt !== 16'd9) begin
      $display("FAIL bp_end: got valid=%b cnt=%0d required 0/9", rsp_valid, issue_cnt); fails++;
    end
  endtask

  task automatic test_fairness();
    req_a[48 +: 16] = 16'd2; req_b[48 +: 16] = 16'd3;
    req_a[0 +: 16]  = 16'd4; req_b[0 +: 16]  = 16'd5;
    req_valid = 4'b1000;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      $display("FAIL fair_only3: got %b required 1000", req_ready); fails++;
    end
    tick();
    req_valid = 4'b1001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      $display("FAIL fair_wrap0: got %b required 0001", req_ready); fails++;
    end
    tick();
    req_valid = 4'b1000;
    #1;
    checks++;
    if (req_ready !== 4'b1000 || rsp_id !== 2'd3 || rsp_z !== 32'd6) begin
      $display("FAIL fair_then3: got ready=%b id=%0d z=%0d required 1000/3/6", req_ready, rsp_id, $signed(rsp_z));
      fails++;
    end
    tick();
    req_valid = '0;
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_z !== 32'd20) begin
      $display("FAIL fair_rsp0: got valid=%b id=%0d z=%0d required 1/0/20", rsp_valid, rsp_id, $signed(rsp_z));
      fails++;
    end
    tick();
    tick();
  endtask

  task automatic test_reset_midflight();
    rsp_ready = 1'b0;
    req_a[0 +: 16] = 16'd1;  req_b[0 +: 16] = 16'd1;
    req_a[16 +: 16] = 16'd2; req_b[16 +: 16] = 16'd2;
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || mul_a !== 16'd2) begin
      $display("FAIL mid_full: got valid=%b a=%0h required 1/2", rsp_valid, mul_a); fails++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || issue_cnt !== 16'd0 || mul_a !== 16'd0) begin
      $display("FAIL mid_async: got valid=%b cnt=%0d a=%0h required 0/0/0", rsp_valid, issue_cnt, mul_a);
      fails++;
    end
    tick();
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || mul_a !== 16'd0) begin
        $display("FAIL mid_stale[%0d]: got valid=%b a=%0h required 0/0", k, rsp_valid, mul_a); fails++;
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    rsp_ready = 1'b1;
    req_a[0 +: 16] = 16'd3; req_b[0 +: 16] = 16'd3;
    req_valid = 4'b0001;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 14 || k == 15 || k == 16 || k == 20) begin
        #1;
        checks++;
        if (s_issue_cnt !== 4'((k > 15) ? 15 : k) || issue_cnt !== 16'(k)) begin
          $display("FAIL sat_cnt[%0d]: got sat=%0d wide=%0d required %0d/%0d",
                   k, s_issue_cnt, issue_cnt, (k > 15) ? 15 : k, k);
          fails++;
        end
      end
    end
    req_valid = '0;
    tick();
    tick();
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_single_op();
    test_round_robin();
    test_backpressure();
    test_fairness();
    test_reset_midflight();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/alm_mul_arbiter.md
Name: alm_mul_arbiter

Overview:
- Shares one combinational 16x16 signed approximate log multiplier between N_REQ requesters.
- Round-robin arbitration selects one operand pair per cycle, holds it in an issue register that drives the multiplier, and captures the product in a result register with the requester ID.
- Single response channel with valid/ready backpressure; two-stage pipeline; sustains one operation per cycle.
- The multiplier sits outside this block, wired to the o_mul_*/i_mul_z ports.

Parameters:
- N_REQ, 4, number of requesters (1..16).
- ID_W, 2, requester ID width; must equal max(1, clog2(N_REQ)).
- CNT_W, 16, width of the issued-operation counter.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_req_valid  input  N_REQ  per-requester request valid.
- o_req_ready  output  N_REQ  per-requester grant/accept, one-hot or zero.
- i_req_a  input  16*N_REQ  signed operand A; requester i occupies bits [16i+15:16i].
- i_req_b  input  16*N_REQ  signed operand B; same packing as i_req_a.
- o_mul_a  output  16  operand A to the shared multiplier.
- o_mul_b  output  16  operand B to the shared multiplier.
- i_mul_z  input  32  signed product returned by the multiplier (combinational from o_mul_a/o_mul_b).
- o_rsp_valid  output  1  response valid.
- i_rsp_ready  input  1  response consumer ready.
- o_rsp_id  output  ID_W  index of the requester that owns the response.
- o_rsp_z  output  32  product.
- o_issue_cnt  output  CNT_W  saturating count of accepted requests.

Behaviour:
- Reset (async assert, sync-safe deassert): all valids 0, rr_ptr 0, o_issue_cnt 0, o_rsp_id 0, o_rsp_z 0, o_mul_a/o_mul_b 0, o_req_ready 0.
- Stage S1 (issue register): holds s1_valid, s1_id, s1_a, s1_b.
  - o_mul_a = s1_a and o_mul_b = s1_b when s1_valid; both 0 otherwise.
- Stage S2 (result register): holds s2_valid, s2_id, s2_z.
  - o_rsp_valid = s2_valid, o_rsp_id = s2_id, o_rsp_z = s2_z.
- Advance rules:
  - s2_load = s1_valid & (!s2_valid | i_rsp_ready).
  - s1_free = !s1_valid | s2_load.
  - On s2_load: s2 <= {1, s1_id, i_mul_z}.
  - When s2_valid & i_rsp_ready & !s2_load: s2_valid <= 0.
- Arbitration (combinational, only when s1_free):
  - Grant the first requester with valid set, scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - o_req_ready = one-hot of the grant; all zero when !s1_free or no valid request.
- Accept: a handshake with requester g loads S1 with {1, g, a_g, b_g}, sets rr_ptr <= (g+1) mod N_REQ and increments o_issue_cnt, saturating at all-ones.
- No accept: if s1_free, s1_valid <= 0; rr_ptr is unchanged.
- Latency: accepted at edge t, o_rsp_valid rises after edge t+1 (visible in cycle t+1 to t+2). With i_rsp_ready held high, throughput is 1 op/cycle.
- Backpressure:
  - While o_rsp_valid & !i_rsp_ready, o_rsp_id and o_rsp_z hold stable.
  - S1 holds its contents and o_mul_a/o_mul_b stay constant.
  - With S1 and S2 both full, all o_req_ready = 0.
  - No response is dropped or duplicated.
- Requester contract: o_req_ready may depend on i_req_valid. Requesters must not make valid depend on ready, and must hold a and b stable while valid is high and not yet accepted.
- Ordering: responses leave in acceptance order.
- N_REQ=1: the requester is granted whenever s1_free; rr_ptr stays 0.
- Reset mid-operation: in-flight S1/S2 contents are discarded, with no response after reset.
- Zero operands are passed through unmodified; the multiplier returns 0.

Test Plan:
- Single op: requester 2 sends a=300, b=-7, i_rsp_ready=1 -> o_req_ready=0100 for one cycle, o_mul_a=300/o_mul_b=-7 the next cycle, o_rsp_valid with id=2 and z=i_mul_z (-2100 with an exact model) two cycles after accept, o_issue_cnt=1.
- Round-robin: all four requesters valid continuously, ready=1 -> grant order 0,1,2,3,0,1; response ids match that order; one response per cycle.
- Backpressure: i_rsp_ready=0 for 5 cycles with requesters 0 and 1 valid -> exactly 2 accepts, then all o_req_ready=0, o_rsp_id/z stable; on releasing ready, responses drain in order with no loss.
- Pointer fairness: only requester 3 valid, then 0 and 3 valid -> after granting 3, rr_ptr=0 and requester 0 wins next.
- Reset mid-flight: assert i_rst with S1 and S2 full -> o_rsp_valid=0 and o_issue_cnt=0 immediately (async); no stale response after deassert.
- Counter saturation: with CNT_W=4, 20 accepts -> o_issue_cnt=15.
